// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: shared types and register map for the NAND command sequencer.
// Register addresses and status bit positions follow nand_avalon.
package nand_seq_pkg;

  typedef enum logic [7:0] {
    CMD_NOP             = 8'd0,
    CMD_RESET           = 8'd1,
    CMD_SYNC_RESET      = 8'd2,
    CMD_READ_ID         = 8'd3,
    CMD_READ_PARAM      = 8'd4,
    CMD_READ_STATUS     = 8'd5,
    CMD_READ_PAGE       = 8'd6,
    CMD_READ_PAGE_CACHE = 8'd7,
    CMD_READ_PAGE_END   = 8'd8,
    CMD_PROG_PAGE       = 8'd9,
    CMD_PROG_PAGE_CACHE = 8'd10,
    CMD_ERASE_BLOCK     = 8'd11,
    CMD_SET_FEATURE     = 8'd12,
    CMD_GET_FEATURE     = 8'd13,
    CMD_READ_BYTE       = 8'd14,
    CMD_WRITE_BYTE      = 8'd15,
    CMD_SET_COL         = 8'd16,
    CMD_LOAD_DATA       = 8'd17,
    CMD_SET_ADDR        = 8'd18,
    CMD_CHIP_ENABLE     = 8'd19,
    CMD_CHIP_DISABLE    = 8'd20,
    CMD_WP_ON           = 8'd21,
    CMD_WP_OFF          = 8'd22,
    CMD_READ_UNIQUE     = 8'd23
  } e_cmd;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'd0,
    OP_WRITE_DATA = 2'd1,
    OP_READ       = 2'd2,
    OP_RSVD       = 2'd3
  } e_op;

  localparam logic [1:0] DATA_REG   = 2'd0;
  localparam logic [1:0] CMD_REG    = 2'd1;
  localparam logic [1:0] STATUS_REG = 2'd2;

  localparam int ST_FAIL = 0;
  localparam int ST_RDY  = 1;

  function automatic logic st_ready(input logic [31:0] st);
    return !st[ST_FAIL] && st[ST_RDY];
  endfunction

endpackage

// File: rtl/nand_cmd_sequencer_if.sv
// nand_cmd_sequencer_if: command queue, response and Avalon register bus.
// master = the sequencer side, slave = host front-end plus nand_avalon.
interface nand_cmd_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_code;
  logic [DATA_W-1:0] cmd_data;
  logic [LEN_W-1:0]  cmd_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [1:0]        address;
  logic [31:0]       writedata;
  logic              pwrite;
  logic              pread;
  logic [31:0]       readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_code, cmd_data, cmd_len,
    input  rsp_ready, readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output address, writedata, pwrite, pread
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_code, cmd_data, cmd_len,
    output rsp_ready, readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  address, writedata, pwrite, pread
  );
endinterface

// File: rtl/nand_seq_fifo.sv
// nand_seq_fifo: small synchronous command FIFO with wrap-bit pointers.
// A push while full is only issued by the parent together with a pop.
module nand_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/nand_cmd_sequencer.sv
// nand_cmd_sequencer: Avalon master sequencing queued NAND commands
// through nand_avalon's DATA/CMD/STATUS registers.
module nand_cmd_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 8,
  parameter int LEN_W        = 8,
  parameter int POLL_TIMEOUT = 65535
)(
  input  logic                 clk,
  input  logic                 rst,
  nand_cmd_sequencer_if.master sif,
  output logic                 init_done,
  output logic                 busy,
  output logic [7:0]           err_count
);
  import nand_seq_pkg::*;

  localparam int FW = 2 + 8 + DATA_W + LEN_W;
  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  localparam logic [3:0] S_INIT_LO  = 4'd0;
  localparam logic [3:0] S_INIT_RDY = 4'd1;
  localparam logic [3:0] S_IDLE     = 4'd2;
  localparam logic [3:0] S_WR_DATA  = 4'd3;
  localparam logic [3:0] S_WR_CMD   = 4'd4;
  localparam logic [3:0] S_POLL     = 4'd5;
  localparam logic [3:0] S_RD       = 4'd6;
  localparam logic [3:0] S_RESP     = 4'd7;
  localparam logic [3:0] S_NEXT     = 4'd8;

  logic [3:0]        state;
  logic              ph;
  logic              aborted;
  logic              err_q;
  logic [PW-1:0]     pcnt;
  logic [LEN_W-1:0]  rep;
  e_op               op;
  logic [7:0]        code;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] rsp_q;

  logic [FW-1:0]     f_din;
  logic [FW-1:0]     f_dout;
  logic              f_full;
  logic              f_empty;
  logic              push;
  logic              pop;
  logic [1:0]        h_op;
  logic [7:0]        h_code;
  logic [DATA_W-1:0] h_data;
  logic [LEN_W-1:0]  h_len;

  logic              poll_st;
  logic              st_rdy;
  logic              poll_last;
  logic              unused_rd;

  assign pop  = (state == S_IDLE) && !f_empty;
  assign push = sif.cmd_valid && sif.cmd_ready;

  // A full queue still accepts when the head leaves this cycle.
  assign sif.cmd_ready = init_done && (!f_full || pop);

  assign f_din = {sif.cmd_op, sif.cmd_code,
                  sif.cmd_data, sif.cmd_len};
  assign {h_op, h_code, h_data, h_len} = f_dout;

  nand_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (f_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  assign poll_st = (state == S_INIT_LO) ||
                   (state == S_INIT_RDY) ||
                   (state == S_POLL);
  assign st_rdy    = st_ready(sif.readdata);
  assign poll_last = (pcnt == PW'(POLL_TIMEOUT - 1));
  assign unused_rd = ^sif.readdata;

  always_comb begin
    sif.pwrite    = 1'b0;
    sif.pread     = 1'b0;
    sif.address   = '0;
    sif.writedata = '0;
    unique case (1'b1)
      (state == S_WR_DATA): begin
        sif.pwrite    = 1'b1;
        sif.address   = DATA_REG;
        sif.writedata = 32'(data);
      end
      (state == S_WR_CMD): begin
        sif.pwrite    = 1'b1;
        sif.address   = CMD_REG;
        sif.writedata = {24'b0, code};
      end
      (state == S_RD): begin
        sif.pread   = 1'b1;
        sif.address = DATA_REG;
      end
      (poll_st && ph): begin
        sif.pread   = 1'b1;
        sif.address = STATUS_REG;
      end
      default: ;
    endcase
  end

  assign sif.rsp_valid = (state == S_RESP);
  assign sif.rsp_data  = rsp_q;
  assign sif.rsp_err   = err_q;
  assign busy = init_done && ((state != S_IDLE) || !f_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT_LO;
      ph        <= 1'b0;
      aborted   <= 1'b0;
      err_q     <= 1'b0;
      pcnt      <= '0;
      rep       <= '0;
      op        <= OP_WRITE;
      code      <= '0;
      data      <= '0;
      rsp_q     <= '0;
      init_done <= 1'b0;
      err_count <= '0;
    end else begin
      unique case (state)
        S_INIT_LO: begin
          ph <= ~ph;
          if (ph && !sif.readdata[ST_RDY])
            state <= S_INIT_RDY;
        end
        S_INIT_RDY: begin
          ph <= ~ph;
          if (ph && st_rdy) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!f_empty) begin
            op      <= e_op'(h_op);
            code    <= h_code;
            data    <= h_data;
            aborted <= 1'b0;
            rep     <= (h_len == '0) ? LEN_W'(1) : h_len;
            if (h_op == OP_RSVD)
              state <= S_IDLE;
            else if (h_op == OP_WRITE_DATA)
              state <= S_WR_DATA;
            else
              state <= S_WR_CMD;
          end
        end
        S_WR_DATA: state <= S_WR_CMD;
        S_WR_CMD: begin
          state <= S_POLL;
          ph    <= 1'b1;
          pcnt  <= '0;
        end
        S_POLL: begin
          ph <= ~ph;
          if (ph) begin
            pcnt <= pcnt + PW'(1);
            if (st_rdy) begin
              state <= (op == OP_READ) ? S_RD : S_NEXT;
            end else if (poll_last) begin
              // Timeout: report once, drop remaining repetitions.
              rsp_q   <= '0;
              err_q   <= 1'b1;
              aborted <= 1'b1;
              state   <= S_RESP;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            end
          end
        end
        S_RD: begin
          rsp_q <= sif.readdata[DATA_W-1:0];
          err_q <= 1'b0;
          state <= S_RESP;
        end
        S_RESP: begin
          if (sif.rsp_ready)
            state <= aborted ? S_IDLE : S_NEXT;
        end
        S_NEXT: begin
          rep <= rep - LEN_W'(1);
          if (rep == LEN_W'(1))
            state <= S_IDLE;
          else if (op == OP_WRITE_DATA)
            state <= S_WR_DATA;
          else
            state <= S_WR_CMD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// tb_nand_cmd_sequencer: directed vectors against a small nand_avalon
// status/data model with a negedge bus and response monitor.
module tb_nand_cmd_sequencer;
  import nand_seq_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int FD = 4;
  localparam int PT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done;
  logic       busy;
  logic [7:0] err_count;

  nand_cmd_sequencer_if #(.DATA_W(DW), .LEN_W(LW)) sif();

  nand_cmd_sequencer #(
    .FIFO_DEPTH   (FD),
    .DATA_W       (DW),
    .LEN_W        (LW),
    .POLL_TIMEOUT (PT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sif       (sif),
    .init_done (init_done),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // NAND register model
  logic [7:0] id_tab [8] = '{8'h2C, 8'h44, 8'h44, 8'h4B,
                             8'hA9, 8'h00, 8'h3C, 8'hC3};
  int         stat_reads = 0;
  logic [2:0] rd_idx = '0;
  logic       stuck = 1'b0;
  logic [1:0] st;

  always_comb begin
    st = 2'b10;
    if (stuck) st = 2'b11;
    else if (stat_reads == 10) st = 2'b00;
    sif.readdata = '0;
    if (sif.pread) begin
      if (sif.address == 2'd2)
        sif.readdata = {30'b0, st};
      else
        sif.readdata = {24'b0, id_tab[rd_idx]};
    end
  end

  always @(posedge clk) begin
    if (sif.pread && sif.address == 2'd2) stat_reads <= stat_reads + 1;
    if (sif.pread && sif.address == 2'd0) rd_idx <= rd_idx + 3'd1;
  end

  // Bus and response monitor
  logic [33:0] wq[$];
  logic [1:0]  rq[$];
  logic [8:0]  rspq[$];
  int viol_both = 0;
  int viol_idle = 0;
  int viol_init = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (sif.pwrite && sif.pread) viol_both++;
      if (!sif.pwrite && !sif.pread &&
          (sif.address != 0 || sif.writedata != 0)) viol_idle++;
      if (sif.pwrite && !init_done) viol_init++;
      if (sif.pwrite) wq.push_back({sif.address, sif.writedata});
      if (sif.pread) rq.push_back(sif.address);
      if (sif.rsp_valid && sif.rsp_ready)
        rspq.push_back({sif.rsp_err, sif.rsp_data});
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] code,
                      input logic [7:0] data, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    sif.cmd_op    = op;
    sif.cmd_code  = code;
    sif.cmd_data  = data;
    sif.cmd_len   = len;
    sif.cmd_valid = 1'b1;
    while (!sif.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!sif.cmd_ready) chk("push_timeout", 0, 1);
    @(negedge clk);
    sif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic clr();
    wq.delete();
    rq.delete();
    rspq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    sif.cmd_valid = 1'b0;
    sif.cmd_op    = '0;
    sif.cmd_code  = '0;
    sif.cmd_data  = '0;
    sif.cmd_len   = '0;
    sif.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_outs", {sif.pwrite, sif.pread, init_done, sif.cmd_ready,
                       busy, sif.rsp_valid, sif.rsp_err, err_count}, 0);
    chk("reset_bus", {sif.address, sif.writedata, sif.rsp_data}, 0);
    rst = 1'b0;

    // Power-up: 10 x st=10, one st=00, one ready read
    @(negedge clk);
    chk("rdy_pre_init", sif.cmd_ready, 0);
    n = 0;
    while (!init_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", init_done, 1);
    chk("init_reads", stat_reads, 12);
    chk("init_busy", busy, 0);
    chk("init_cmd_ready", sif.cmd_ready, 1);
    chk("init_no_write", wq.size(), 0);

    // WRITE code 9, len 1
    clr();
    push(OP_WRITE, 8'd9, 8'h00, 8'd1);
    wait_idle(n);
    chk("wr_cycles", n, 4);
    chk("wr_count", wq.size(), 1);
    chk("wr_word", wq.size() > 0 ? wq[0] : 34'h0, {2'd1, 32'd9});
    chk("wr_reads", rq.size(), 1);
    chk("wr_read_addr", rq.size() > 0 ? rq[0] : 2'd0, 2'd2);
    chk("wr_no_rsp", rspq.size(), 0);

    // Reserved op: dropped without any access
    clr();
    push(OP_RSVD, 8'd5, 8'h00, 8'd1);
    wait_idle(n);
    chk("rsvd_bus", wq.size() + rq.size() + rspq.size(), 0);

    // READ code 14, len 6: ID bytes in order
    clr();
    push(OP_READ, 8'd14, 8'h00, 8'd6);
    n = 0;
    while (!sif.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, 4);
    wait_idle(n);
    chk("rd_rsp_count", rspq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rd_rsp%0d", i),
          rspq.size() > i ? rspq[i] : 9'h1FF, {1'b0, id_tab[i]});
    chk("rd_cmd_writes", wq.size(), 6);

    // WRITE_DATA code 17, data 5A, len 100
    clr();
    push(OP_WRITE_DATA, 8'd17, 8'h5A, 8'd100);
    wait_idle(n);
    chk("wd_cycles", n, 401);
    chk("wd_count", wq.size(), 200);
    bad = 0;
    for (int i = 0; i + 1 < wq.size(); i += 2)
      if (wq[i] !== {2'd0, 32'h5A} || wq[i+1] !== {2'd1, 32'd17}) bad++;
    chk("wd_pairs", bad, 0);
    chk("wd_no_rsp", rspq.size(), 0);

    // Stalled response, queue fills behind it
    clr();
    sif.rsp_ready = 1'b0;
    push(OP_READ, 8'd14, 8'h00, 8'd2);
    n = 0;
    while (!sif.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", sif.rsp_valid, 1);
    clr();
    for (int i = 1; i <= FD; i++)
      push(OP_WRITE, 8'(i), 8'h00, 8'd1);
    chk("full_cmd_ready", sif.cmd_ready, 0);
    chk("full_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!sif.rsp_valid || sif.rsp_data !== 8'h3C || sif.rsp_err) bad++;
    end
    chk("stall_stable", bad, 0);
    chk("stall_bus", wq.size() + rq.size(), 0);
    chk("stall_no_hs", rspq.size(), 0);
    sif.rsp_ready = 1'b1;
    wait_idle(n);
    chk("stall_rsp_count", rspq.size(), 2);
    chk("stall_rsp0", rspq.size() > 0 ? rspq[0] : 9'h1FF, {1'b0, 8'h3C});
    chk("stall_rsp1", rspq.size() > 1 ? rspq[1] : 9'h1FF, {1'b0, 8'hC3});
    chk("drain_writes", wq.size(), 5);
    chk("drain_last", wq.size() > 4 ? wq[4] : 34'h0, {2'd1, 32'd4});

    // Poll timeout on READ len 3
    clr();
    stuck = 1'b1;
    push(OP_READ, 8'd14, 8'h00, 8'd3);
    wait_idle(n);
    chk("to_rsp_count", rspq.size(), 1);
    chk("to_rsp", rspq.size() > 0 ? rspq[0] : 9'h0, {1'b1, 8'h00});
    chk("to_reads", rq.size(), PT);
    chk("to_err_count", err_count, 1);
    clr();
    stuck = 1'b0;
    push(OP_WRITE, 8'd3, 8'h00, 8'd0);
    wait_idle(n);
    chk("after_to_write", wq.size() > 0 ? wq[0] : 34'h0, {2'd1, 32'd3});
    chk("after_to_count", wq.size(), 1);
    chk("after_to_rsp", rspq.size(), 0);

    chk("strobe_overlap", viol_both, 0);
    chk("idle_bus_zero", viol_idle, 0);
    chk("write_pre_init", viol_init, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
